dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the byte-addressed, big-endian 64-bit data memory. Port 0 is the pipeline MEM stage and port 1 is the loader/debug port. The block grants one access per cycle and drives the memory's Address, WriteData, MemoryRead and MemoryWrite inputs. It tracks the memory's one-cycle synchronous read latency and returns an acknowledge, with read data or an error, to the port that issued the access.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_arbiter_if.sv | 36 +++
 rtl/rr_arb2.sv | 32 +++
 rtl/dmem_arbiter.sv | 83 ++++++++
 tb/tb_dmem_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants, types and helpers for the data-memory arbiter.
//   MEM_SIZE_DEF    default memory size in bytes
//   PORT_MEM/DBG    requester port indices (pipeline MEM stage / loader-debug)
//   resp_t          response register contents captured on a grant
//   is_legal()      doubleword-access legality check
package dmem_pkg;

  localparam int unsigned MEM_SIZE_DEF = 1024;
  localparam int unsigned NUM_PORTS    = 2;
  localparam int unsigned AW           = 64;
  localparam int unsigned DW           = 64;

  localparam int PORT_MEM = 0;
  localparam int PORT_DBG = 1;

  typedef struct packed {
    logic vld;   // an access was granted last cycle
    logic port;  // which port gets the acknowledge
    logic err;   // the access was rejected
  } resp_t;

  // Aligned doubleword that lies completely inside the memory.
  function automatic logic is_legal(input logic [AW-1:0] addr, input logic [AW-1:0] size);
    return (addr[2:0] == 3'b000) && (size >= 64'd8) && (addr <= size - 64'd8);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester-side and memory-side signals of the arbiter.
//   Req/Wr/Addr*/WData*   per-port requests (from requesters)
//   Gnt/Ack/Err/RData     per-port grant and response (to requesters)
//   Mem*                  memory Address/WriteData/MemoryRead/MemoryWrite/ReadData
// modport slave  : the arbiter's view
// modport master : the requesters + memory view
interface dmem_arbiter_if;
  import dmem_pkg::*;

  logic [1:0]    Req;
  logic [1:0]    Wr;
  logic [AW-1:0] Addr0;
  logic [AW-1:0] Addr1;
  logic [DW-1:0] WData0;
  logic [DW-1:0] WData1;
  logic [1:0]    Gnt;
  logic [1:0]    Ack;
  logic [1:0]    Err;
  logic [DW-1:0] RData;
  logic [AW-1:0] MemAddress;
  logic [DW-1:0] MemWriteData;
  logic          MemRead;
  logic          MemWrite;
  logic [DW-1:0] MemReadData;

  modport slave (
    input  Req, Wr, Addr0, Addr1, WData0, WData1, MemReadData,
    output Gnt, Ack, Err, RData, MemAddress, MemWriteData, MemRead, MemWrite
  );

  modport master (
    output Req, Wr, Addr0, Addr1, WData0, WData1, MemReadData,
    input  Gnt, Ack, Err, RData, MemAddress, MemWriteData, MemRead, MemWrite
  );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester arbiter, round-robin or fixed priority.
//   clk, rst_n  clock, async active-low reset
//   req[1:0]    request levels
//   rr_en       1 = round-robin on contention, 0 = port 0 always wins
//   gnt[1:0]    one-hot grant, combinational from req and last winner
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       rr_en,
  output logic [1:0] gnt
);

  // Winner of the most recent grant; resets to 1 so port 0 wins first.
  logic last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (rr_en && !last) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last <= 1'b1;
    else if (|req)   last <= gnt[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: grants one memory access per cycle between the pipeline MEM
// stage (port 0) and the loader/debug port (port 1), drives the memory
// strobes, and returns Ack/Err (and passes RData) one cycle after the grant.
//   Clock, ResetL  clock, async active-low reset
//   bus            dmem_arbiter_if.slave: requests, grants, responses, memory
// Parameters: MEM_SIZE (bytes), RR_EN (1 = round-robin, 0 = port 0 priority)
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_SIZE = MEM_SIZE_DEF,
  parameter bit          RR_EN    = 1'b1
) (
  input logic            Clock,
  input logic            ResetL,
  dmem_arbiter_if.slave  bus
);

  logic [NUM_PORTS-1:0]         req;
  logic [NUM_PORTS-1:0]         gnt;
  logic [NUM_PORTS-1:0][AW-1:0] addr;
  logic [NUM_PORTS-1:0][DW-1:0] wdata;
  logic                         sel;
  logic                         any_gnt;
  logic                         legal;
  logic                         sel_wr;
  logic [AW-1:0]                addr_q;
  logic [DW-1:0]                wdata_q;
  resp_t                        resp_q;

  assign addr[PORT_MEM]  = bus.Addr0;
  assign addr[PORT_DBG]  = bus.Addr1;
  assign wdata[PORT_MEM] = bus.WData0;
  assign wdata[PORT_DBG] = bus.WData1;

  // Masking requests during reset keeps Gnt and the memory strobes at 0.
  assign req = bus.Req & {NUM_PORTS{ResetL}};

  rr_arb2 u_arb (
    .clk   (Clock),
    .rst_n (ResetL),
    .req   (req),
    .rr_en (RR_EN),
    .gnt   (gnt)
  );

  assign bus.Gnt = gnt;
  assign any_gnt = |gnt;
  assign sel     = gnt[PORT_DBG];
  assign sel_wr  = bus.Wr[sel];
  assign legal   = is_legal(addr[sel], AW'(MEM_SIZE));

  // Address/data follow the granted port; with no grant they hold the last
  // granted values so the memory inputs do not toggle while idle.
  assign bus.MemAddress   = any_gnt ? addr[sel]  : addr_q;
  assign bus.MemWriteData = any_gnt ? wdata[sel] : wdata_q;
  assign bus.MemRead      = any_gnt && legal && !sel_wr;
  assign bus.MemWrite     = any_gnt && legal &&  sel_wr;

  always_ff @(posedge Clock or negedge ResetL) begin
    if (!ResetL) begin
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
    end else begin
      if (any_gnt) begin
        addr_q  <= addr[sel];
        wdata_q <= wdata[sel];
      end
      resp_q.vld  <= any_gnt;
      resp_q.port <= sel;
      resp_q.err  <= !legal;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign bus.Ack[p] = resp_q.vld && (resp_q.port == 1'(p));
    assign bus.Err[p] = resp_q.vld && (resp_q.port == 1'(p)) && resp_q.err;
  end

  // Memory read latency is one cycle, so read data lines up with Ack.
  assign bus.RData = bus.MemReadData;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int unsigned MS = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bi ();
  dmem_arbiter_if bf ();

  dmem_arbiter #(.MEM_SIZE(MS), .RR_EN(1'b1)) dut (.Clock(clk), .ResetL(rst_n), .bus(bi));
  dmem_arbiter #(.MEM_SIZE(MS), .RR_EN(1'b0)) dut_fp (.Clock(clk), .ResetL(rst_n), .bus(bf));

  assign bf.MemReadData = 64'h0;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory device model (big-endian bytes) ----------------
  logic [7:0]  dmem [MS];
  logic [63:0] rd = 64'h0;
  bit          filled = 1'b0;
  assign bi.MemReadData = rd;

  always @(posedge clk) begin
    logic [63:0] t;
    int          ix;
    if (!filled) begin
      for (int k = 0; k < int'(MS); k++) dmem[k] <= 8'(k * 37 + 5);
      filled <= 1'b1;
    end else begin
      ix = int'(bi.MemAddress[31:0]);
      if (bi.MemWrite && bi.MemAddress <= 64'(MS - 8))
        for (int k = 0; k < 8; k++) dmem[ix + k] <= bi.MemWriteData[63 - 8*k -: 8];
      if (bi.MemRead && bi.MemAddress <= 64'(MS - 8)) begin
        t = '0;
        for (int k = 0; k < 8; k++) t[63 - 8*k -: 8] = dmem[ix + k];
        rd <= t;
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct { bit v; bit wr; logic [63:0] a; logic [63:0] d; } rq_t;
  typedef struct { int unsigned due; int port; bit err; bit load; logic [63:0] data; } exp_t;

  logic [63:0] ref_mem [MS/8];
  rq_t         pend [2];
  exp_t        q [$];
  int          last_w;
  logic [63:0] last_addr;
  bit          addr_known;
  bit          mon_en = 1'b0;
  int          vec = 0;
  int          errs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit ref_legal(input logic [63:0] a);
    return (a % 8 == 0) && (a < 64'(MS) - 7);
  endfunction

  task automatic drive();
    bi.Req    = {pend[1].v, pend[0].v};
    bi.Wr     = {pend[1].wr, pend[0].wr};
    bi.Addr0  = pend[0].a;
    bi.Addr1  = pend[1].a;
    bi.WData0 = pend[0].d;
    bi.WData1 = pend[1].d;
  endtask

  // Called at a negedge: present pending requests, check the grant against
  // the arbitration rules, and queue the response expected next cycle.
  task automatic step();
    int          w;
    logic [1:0]  eg;
    logic [63:0] a;
    bit          legal;
    exp_t        e;
    drive();
    #1;
    if (pend[0].v && pend[1].v) w = (last_w == 0) ? 1 : 0;
    else if (pend[0].v)         w = 0;
    else if (pend[1].v)         w = 1;
    else                        w = -1;
    eg = (w < 0) ? 2'b00 : (w == 0 ? 2'b01 : 2'b10);
    chk("gnt", 64'(bi.Gnt), 64'(eg));
    if (w >= 0) begin
      a     = pend[w].a;
      legal = ref_legal(a);
      chk("mem_read",  64'(bi.MemRead),  64'(legal && !pend[w].wr));
      chk("mem_write", 64'(bi.MemWrite), 64'(legal &&  pend[w].wr));
      if (legal) begin
        chk("mem_addr", bi.MemAddress, a);
        if (pend[w].wr) begin
          chk("mem_wdata", bi.MemWriteData, pend[w].d);
          ref_mem[int'(a / 8)] = pend[w].d;
        end
        last_addr  = a;
        addr_known = 1'b1;
      end else begin
        addr_known = 1'b0;
      end
      e.due  = cyc + 1;
      e.port = w;
      e.err  = !legal;
      e.load = !pend[w].wr;
      e.data = legal ? ref_mem[int'(a / 8)] : 64'h0;
      q.push_back(e);
      pend[w].v = 1'b0;
      last_w    = w;
    end else begin
      chk("idle_read",  64'(bi.MemRead),  64'h0);
      chk("idle_write", 64'(bi.MemWrite), 64'h0);
      if (addr_known) chk("idle_addr_hold", bi.MemAddress, last_addr);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    step();
  endtask

  task automatic setreq(input int p, input bit wr, input logic [63:0] a, input logic [63:0] d);
    pend[p].v  = 1'b1;
    pend[p].wr = wr;
    pend[p].a  = a;
    pend[p].d  = d;
  endtask

  // Monitor: compares the response whenever one is due, else requires no Ack.
  always @(negedge clk) begin
    exp_t        e;
    logic [1:0]  ea;
    if (mon_en) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e  = q.pop_front();
        ea = (e.port == 0) ? 2'b01 : 2'b10;
        chk("ack", 64'(bi.Ack), 64'(ea));
        chk("err", 64'(bi.Err), e.err ? 64'(ea) : 64'h0);
        if (e.load && !e.err) chk("rdata", bi.RData, e.data);
      end else begin
        chk("no_ack", 64'(bi.Ack), 64'h0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] rand_addr();
    int unsigned r = $urandom_range(0, 99);
    logic [63:0] base = 64'($urandom_range(0, 7) * 8) + (($urandom_range(0, 1) != 0) ? 64'(MS - 64) : 64'h0);
    if (r < 70) return base;
    if (r < 85) return base + 64'($urandom_range(1, 7));
    case ($urandom_range(0, 3))
      0:       return 64'(MS - 4);
      1:       return 64'(MS);
      2:       return 64'(MS + 8);
      default: return 64'hFFFF_FFFF_FFFF_FFF8;
    endcase
  endfunction

  initial begin
    for (int w = 0; w < int'(MS / 8); w++)
      for (int k = 0; k < 8; k++) ref_mem[w][63 - 8*k -: 8] = 8'((w * 8 + k) * 37 + 5);
    pend[0] = '{default: '0};
    pend[1] = '{default: '0};
    last_w = 1; addr_known = 1'b0; last_addr = '0;
    drive();
    bf.Req = 2'b00; bf.Wr = 2'b00; bf.Addr0 = '0; bf.Addr1 = '0; bf.WData0 = '0; bf.WData1 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_gnt", 64'(bi.Gnt), 64'h0);
    chk("rst_ack", 64'(bi.Ack), 64'h0);
    chk("rst_err", 64'(bi.Err), 64'h0);
    chk("rst_memrd", 64'(bi.MemRead), 64'h0);
    chk("rst_memwr", 64'(bi.MemWrite), 64'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Store then load the same doubleword on port 0
    setreq(0, 1'b1, 64'h18, 64'h0FFB_EA7D_EADB_EEFF); step();
    setreq(0, 1'b0, 64'h18, 64'h0); tick();
    tick();
    tick();

    // Illegal accesses on port 1: misaligned and past the end
    setreq(1, 1'b0, 64'h0C, 64'h0); tick();
    setreq(1, 1'b0, 64'(MS - 4), 64'h0); tick();

    // Port 0 store contends with port 1 load of the same address
    setreq(0, 1'b1, 64'h20, 64'hA5A5_0123_4567_89AB);
    setreq(1, 1'b0, 64'h20, 64'h0);
    tick(); tick(); tick();

    // Reset pulse right after a load grant
    setreq(0, 1'b0, 64'h40, 64'h0); tick();
    q.delete();
    @(posedge clk); #1 rst_n = 1'b0;
    setreq(0, 1'b0, 64'h48, 64'h0);
    setreq(1, 1'b0, 64'h50, 64'h0);
    drive();
    repeat (2) begin
      @(negedge clk);
      chk("rstp_gnt", 64'(bi.Gnt), 64'h0);
      chk("rstp_memrd", 64'(bi.MemRead), 64'h0);
      chk("rstp_memwr", 64'(bi.MemWrite), 64'h0);
    end
    rst_n = 1'b1; last_w = 1; addr_known = 1'b0;
    step();

    // Continuous contention: grants must alternate
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p].v) setreq(p, 1'b0, 64'($urandom_range(0, 31) * 8), 64'h0);
      tick();
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p].v && $urandom_range(0, 1) != 0)
          setreq(p, 1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom});
      tick();
    end
    while (pend[0].v || pend[1].v) tick();
    repeat (3) tick();

    // Fixed-priority instance: port 1 starves while port 0 holds Req
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bf.Req = 2'b11; bf.Addr0 = 64'(i * 8); bf.Addr1 = 64'h100;
      #1 chk("fp_gnt_contend", 64'(bf.Gnt), 64'h1);
    end
    @(negedge clk);
    bf.Req = 2'b10;
    #1 chk("fp_gnt_p1", 64'(bf.Gnt), 64'h2);
    @(negedge clk);
    bf.Req = 2'b00;
    #1 chk("fp_gnt_idle", 64'(bf.Gnt), 64'h0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
